// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals between the ALU arbiter (slave) and its
// requesters, ALU and response consumer (master).
interface alu_arbiter_if #(
   parameter int unsigned TAG_W = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [31:0]      req0_lhs;
   logic [31:0]      req0_rhs;
   logic [4:0]       req0_uop;
   logic             req0_set_flags;
   logic [TAG_W-1:0] req0_tag;

   logic             req1_valid;
   logic             req1_ready;
   logic [31:0]      req1_lhs;
   logic [31:0]      req1_rhs;
   logic [4:0]       req1_uop;
   logic             req1_set_flags;
   logic [TAG_W-1:0] req1_tag;

   logic [31:0]      alu_lhs;
   logic [31:0]      alu_rhs;
   logic [4:0]       alu_uop;
   logic [31:0]      alu_result;
   logic [3:0]       alu_flags;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [31:0]      rsp_result;
   logic [3:0]       rsp_flags;
   logic [TAG_W-1:0] rsp_tag;
   logic [3:0]       flags_q;

   modport slave (
      input  req0_valid, req0_lhs, req0_rhs, req0_uop, req0_set_flags, req0_tag,
      output req0_ready,
      input  req1_valid, req1_lhs, req1_rhs, req1_uop, req1_set_flags, req1_tag,
      output req1_ready,
      output alu_lhs, alu_rhs, alu_uop,
      input  alu_result, alu_flags,
      output rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_tag, flags_q,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_lhs, req0_rhs, req0_uop, req0_set_flags, req0_tag,
      input  req0_ready,
      output req1_valid, req1_lhs, req1_rhs, req1_uop, req1_set_flags, req1_tag,
      input  req1_ready,
      input  alu_lhs, alu_rhs, alu_uop,
      output alu_result, alu_flags,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_tag, flags_q,
      output rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the execute stage (req0) and the
// load/store unit (req1); buffers one response and owns the NZCV register.
module alu_arbiter #(
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned ARB_MODE  = 0,
   parameter int unsigned MAX_WAIT  = 8,
   parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);
   localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   localparam logic [4:0] UOP_NOP = 5'd0;
   localparam logic [4:0] UOP_ADD = 5'd1;
   localparam logic [4:0] UOP_SUB = 5'd2;
   localparam logic [4:0] UOP_AND = 5'd3;
   localparam logic [4:0] UOP_EOR = 5'd4;
   localparam logic [4:0] UOP_CMP = 5'd5;
   localparam logic [4:0] UOP_LSL = 5'd6;
   localparam logic [4:0] UOP_LSR = 5'd7;
   localparam logic [4:0] UOP_MOV = 5'd8;

   // LDR/STR and undefined encodings fall to default: they never touch NZCV.
   function automatic logic uop_sets_flags(input logic [4:0] uop);
      logic sets;
      case (uop)
         UOP_ADD, UOP_SUB, UOP_AND, UOP_EOR,
         UOP_CMP, UOP_LSL, UOP_LSR, UOP_MOV: sets = 1'b1;
         default:                            sets = 1'b0;
      endcase
      return sets;
   endfunction

   logic              can_issue_s;
   logic              grant0_s;
   logic              grant1_s;
   logic              set_flags_s;
   logic [TAG_W-1:0]  tag_s;

   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [31:0]       rsp_result_q, rsp_result_d;
   logic [3:0]        rsp_flags_q, rsp_flags_d;
   logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
   logic [3:0]        arch_flags_q, arch_flags_d;
   logic              rr_q, rr_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   assign can_issue_s = !rst && (!rsp_valid_q || bus.rsp_ready);

   // Arbitration: rr_q names the requester that wins a tie in round-robin mode.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (can_issue_s) begin
         if (ARB_MODE == 32'd1) begin
            if (bus.req1_valid && ((wait_q == WAIT_MAX) || !bus.req0_valid)) begin
               grant1_s = 1'b1;
            end else begin
               grant0_s = bus.req0_valid;
            end
         end else begin
            if (bus.req0_valid && bus.req1_valid) begin
               grant0_s = !rr_q;
               grant1_s = rr_q;
            end else begin
               grant0_s = bus.req0_valid;
               grant1_s = bus.req1_valid;
            end
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   assign bus.req0_ready = grant0_s;
   assign bus.req1_ready = grant1_s;

   // ALU operand mux; idle cycles present a NOP with zero operands.
   always_comb begin
      bus.alu_lhs = 32'd0;
      bus.alu_rhs = 32'd0;
      bus.alu_uop = UOP_NOP;
      set_flags_s = 1'b0;
      tag_s       = '0;
      if (grant0_s) begin
         bus.alu_lhs = bus.req0_lhs;
         bus.alu_rhs = bus.req0_rhs;
         bus.alu_uop = bus.req0_uop;
         set_flags_s = bus.req0_set_flags;
         tag_s       = bus.req0_tag;
      end else if (grant1_s) begin
         bus.alu_lhs = bus.req1_lhs;
         bus.alu_rhs = bus.req1_rhs;
         bus.alu_uop = bus.req1_uop;
         set_flags_s = bus.req1_set_flags;
         tag_s       = bus.req1_tag;
      end else begin
         set_flags_s = 1'b0;
      end
   end

   // Next state of the response buffer, NZCV, rr pointer and req1 wait counter.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      rsp_tag_d    = rsp_tag_q;
      arch_flags_d = arch_flags_q;
      rr_d         = rr_q;
      wait_d       = wait_q;

      if (grant0_s || grant1_s) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant1_s;
         rsp_result_d = bus.alu_result;
         rsp_flags_d  = bus.alu_flags;
         rsp_tag_d    = tag_s;
         rr_d         = grant0_s;
         if (set_flags_s && uop_sets_flags(bus.alu_uop)) begin
            arch_flags_d = bus.alu_flags;
         end else begin
            arch_flags_d = arch_flags_q;
         end
      end else if (bus.rsp_ready) begin
         rsp_valid_d = 1'b0;
      end else begin
         rsp_valid_d = rsp_valid_q;
      end

      if (!bus.req1_valid || grant1_s) begin
         wait_d = '0;
      end else if (wait_q != WAIT_MAX) begin
         wait_d = wait_q + WAIT_W'(1);
      end else begin
         wait_d = wait_q;
      end
   end

   // State registers; reset drops any buffered response immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_result_q <= 32'd0;
         rsp_flags_q  <= 4'd0;
         rsp_tag_q    <= '0;
         arch_flags_q <= FLAGS_RST;
         rr_q         <= 1'b0;
         wait_q       <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         rsp_tag_q    <= rsp_tag_d;
         arch_flags_q <= arch_flags_d;
         rr_q         <= rr_d;
         wait_q       <= wait_d;
      end
   end

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign bus.rsp_tag    = rsp_tag_q;
   assign bus.flags_q    = arch_flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter in round-robin and fixed-priority modes.
module tb_alu_arbiter;
   localparam logic [4:0] OP_NOP = 5'd0, OP_ADD = 5'd1, OP_SUB = 5'd2, OP_AND = 5'd3,
                          OP_EOR = 5'd4, OP_CMP = 5'd5, OP_LSL = 5'd6, OP_LSR = 5'd7,
                          OP_MOV = 5'd8, OP_LDR = 5'd9, OP_STR = 5'd10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passed = 0;

   alu_arbiter_if #(.TAG_W(4)) ifr ();
   alu_arbiter_if #(.TAG_W(4)) ifp ();

   alu_arbiter #(.TAG_W(4), .ARB_MODE(0), .MAX_WAIT(8), .FLAGS_RST(4'b0000))
      dut_rr (.clk(clk), .rst(rst), .bus(ifr));
   alu_arbiter #(.TAG_W(4), .ARB_MODE(1), .MAX_WAIT(3), .FLAGS_RST(4'b1010))
      dut_fp (.clk(clk), .rst(rst), .bus(ifp));

   always #5 clk = ~clk;

   // Reference ALU: returns {N,Z,C,V,result}.
   function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] u);
      logic [32:0] w;
      logic [31:0] r;
      logic        c, v;
      w = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
      case (u)
         OP_ADD, OP_LDR, OP_STR: begin
            w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         OP_SUB, OP_CMP: begin
            r = a - b; c = (a >= b);
            v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         OP_AND: r = a & b;
         OP_EOR: r = a ^ b;
         OP_LSL: r = a << b[4:0];
         OP_LSR: r = a >> b[4:0];
         OP_MOV: r = b;
         default: r = 32'd0;
      endcase
      return {r[31], (r == 32'd0), c, v, r};
   endfunction

   function automatic logic sets_flags(input logic [4:0] u);
      return u inside {OP_ADD, OP_SUB, OP_AND, OP_EOR, OP_CMP, OP_LSL, OP_LSR, OP_MOV};
   endfunction

   always_comb {ifr.alu_flags, ifr.alu_result} = alu_ref(ifr.alu_lhs, ifr.alu_rhs, ifr.alu_uop);
   always_comb {ifp.alu_flags, ifp.alu_result} = alu_ref(ifp.alu_lhs, ifp.alu_rhs, ifp.alu_uop);

   task automatic drv_r(input int n, input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] u, input logic sf, input logic [3:0] t);
      if (n == 0) begin
         ifr.req0_valid = v; ifr.req0_lhs = a; ifr.req0_rhs = b;
         ifr.req0_uop = u; ifr.req0_set_flags = sf; ifr.req0_tag = t;
      end else begin
         ifr.req1_valid = v; ifr.req1_lhs = a; ifr.req1_rhs = b;
         ifr.req1_uop = u; ifr.req1_set_flags = sf; ifr.req1_tag = t;
      end
   endtask

   task automatic idle_all;
      drv_r(0, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b0, 4'd0);
      drv_r(1, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b0, 4'd0);
      ifr.rsp_ready = 1'b1;
      ifp.req0_valid = 1'b0; ifp.req0_lhs = 32'd0; ifp.req0_rhs = 32'd0;
      ifp.req0_uop = OP_NOP; ifp.req0_set_flags = 1'b0; ifp.req0_tag = 4'd0;
      ifp.req1_valid = 1'b0; ifp.req1_lhs = 32'd0; ifp.req1_rhs = 32'd0;
      ifp.req1_uop = OP_NOP; ifp.req1_set_flags = 1'b0; ifp.req1_tag = 4'd0;
      ifp.rsp_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_all();
      @(posedge clk); #1;
      drv_r(0, 1'b1, 32'd1, 32'd2, OP_ADD, 1'b1, 4'd1);
      #1;
      checks++; if (ifr.req0_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ifr.req0_ready); else passed++;
      checks++; if (ifr.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", ifr.rsp_valid); else passed++;
      checks++;
      if ({ifr.rsp_id, ifr.rsp_result, ifr.rsp_flags, ifr.rsp_tag} !== 41'd0)
         $display("FAIL reset_rsp_fields: got %h want 0", {ifr.rsp_id, ifr.rsp_result, ifr.rsp_flags, ifr.rsp_tag});
      else passed++;
      checks++; if (ifr.flags_q !== 4'b0000) $display("FAIL reset_flags_rr: got %b want 0000", ifr.flags_q); else passed++;
      checks++; if (ifp.flags_q !== 4'b1010) $display("FAIL reset_flags_fp: got %b want 1010", ifp.flags_q); else passed++;
      drv_r(0, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b0, 4'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (ifr.rsp_valid !== 1'b0) $display("FAIL reset_release: got %b want 0", ifr.rsp_valid); else passed++;
   endtask

   task automatic test_rr_alternation;
      drv_r(0, 1'b1, 32'd10, 32'd1, OP_MOV, 1'b0, 4'd3);
      drv_r(1, 1'b1, 32'd20, 32'd2, OP_MOV, 1'b0, 4'd12);
      ifr.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({ifr.req0_ready, ifr.req1_ready} !== {(i % 2 == 0), (i % 2 == 1)})
            $display("FAIL rr_grant[%0d]: got %b%b want %b%b", i, ifr.req0_ready, ifr.req1_ready, (i % 2 == 0), (i % 2 == 1));
         else passed++;
         @(posedge clk); #1;
         checks++;
         if (ifr.rsp_id !== (i % 2 == 1) || ifr.rsp_tag !== ((i % 2 == 1) ? 4'd12 : 4'd3))
            $display("FAIL rr_rsp[%0d]: got id %b tag %0d", i, ifr.rsp_id, ifr.rsp_tag);
         else passed++;
      end
      idle_all();
      @(posedge clk); #1;
      checks++; if (ifr.rsp_valid !== 1'b0) $display("FAIL rr_drain: got %b want 0", ifr.rsp_valid); else passed++;
   endtask

   task automatic test_add_flags;
      drv_r(0, 1'b1, 32'hFFFF_FFFF, 32'd1, OP_ADD, 1'b1, 4'd5);
      @(negedge clk);
      checks++; if (ifr.req0_ready !== 1'b1 || ifr.alu_uop !== OP_ADD) $display("FAIL add_issue: got ready %b uop %0d", ifr.req0_ready, ifr.alu_uop); else passed++;
      @(posedge clk); #1;
      idle_all();
      checks++; if (ifr.rsp_result !== 32'd0) $display("FAIL add_result: got %h want 0", ifr.rsp_result); else passed++;
      checks++; if (ifr.rsp_flags !== 4'b0110) $display("FAIL add_rsp_flags: got %b want 0110", ifr.rsp_flags); else passed++;
      checks++; if (ifr.rsp_tag !== 4'd5 || ifr.rsp_id !== 1'b0) $display("FAIL add_tag_id: got tag %0d id %b", ifr.rsp_tag, ifr.rsp_id); else passed++;
      checks++; if (ifr.flags_q !== 4'b0110) $display("FAIL add_flags_q: got %b want 0110", ifr.flags_q); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_ldr_no_flags;
      drv_r(1, 1'b1, 32'h1000, 32'h20, OP_LDR, 1'b1, 4'd9);
      @(posedge clk); #1;
      idle_all();
      checks++; if (ifr.rsp_result !== 32'h1020) $display("FAIL ldr_result: got %h want 00001020", ifr.rsp_result); else passed++;
      checks++; if (ifr.rsp_id !== 1'b1 || ifr.rsp_tag !== 4'd9) $display("FAIL ldr_id_tag: got id %b tag %0d", ifr.rsp_id, ifr.rsp_tag); else passed++;
      checks++; if (ifr.flags_q !== 4'b0110) $display("FAIL ldr_flags_q: got %b want 0110", ifr.flags_q); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      ifr.rsp_ready = 1'b0;
      drv_r(0, 1'b1, 32'd7, 32'd8, OP_ADD, 1'b0, 4'd1);
      @(posedge clk); #1;
      drv_r(0, 1'b1, 32'h0F0, 32'h00F, OP_EOR, 1'b0, 4'd2);
      checks++; if (ifr.rsp_valid !== 1'b1 || ifr.rsp_result !== 32'd15) $display("FAIL stall_load: got v %b res %h", ifr.rsp_valid, ifr.rsp_result); else passed++;
      repeat (2) begin
         @(negedge clk);
         checks++; if (ifr.req0_ready !== 1'b0) $display("FAIL stall_ready: got %b want 0", ifr.req0_ready); else passed++;
         @(posedge clk); #1;
         checks++;
         if (ifr.rsp_valid !== 1'b1 || ifr.rsp_result !== 32'd15 || ifr.rsp_tag !== 4'd1)
            $display("FAIL stall_hold: got v %b res %h tag %0d", ifr.rsp_valid, ifr.rsp_result, ifr.rsp_tag);
         else passed++;
      end
      ifr.rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if (ifr.req0_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", ifr.req0_ready); else passed++;
      @(posedge clk); #1;
      idle_all();
      checks++;
      if (ifr.rsp_valid !== 1'b1 || ifr.rsp_tag !== 4'd2 || ifr.rsp_result !== 32'h0FF)
         $display("FAIL stall_reload: got v %b tag %0d res %h", ifr.rsp_valid, ifr.rsp_tag, ifr.rsp_result);
      else passed++;
      @(posedge clk); #1;
      checks++; if (ifr.rsp_valid !== 1'b0) $display("FAIL stall_empty: got %b want 0", ifr.rsp_valid); else passed++;
   endtask

   task automatic test_fixed_priority;
      logic [4:0] patt;
      patt = 5'b01000;
      ifp.req0_valid = 1'b1; ifp.req0_uop = OP_MOV; ifp.req0_rhs = 32'd1; ifp.req0_tag = 4'd1;
      ifp.req1_valid = 1'b1; ifp.req1_uop = OP_MOV; ifp.req1_rhs = 32'd2; ifp.req1_tag = 4'd2;
      ifp.rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (ifp.req1_ready !== patt[i] || ifp.req0_ready !== !patt[i])
            $display("FAIL fp_grant[%0d]: got r0 %b r1 %b want r1 %b", i, ifp.req0_ready, ifp.req1_ready, patt[i]);
         else passed++;
         @(posedge clk); #1;
      end
      idle_all();
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op;
      ifr.rsp_ready = 1'b0;
      drv_r(0, 1'b1, 32'd1, 32'd2, OP_SUB, 1'b1, 4'd7);
      @(posedge clk); #1;
      drv_r(0, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b0, 4'd0);
      checks++; if (ifr.rsp_valid !== 1'b1 || ifr.flags_q !== 4'b1000) $display("FAIL mid_pre: got v %b flags %b", ifr.rsp_valid, ifr.flags_q); else passed++;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ifr.rsp_valid !== 1'b0 || ifr.flags_q !== 4'b0000 || ifr.rsp_tag !== 4'd0)
         $display("FAIL mid_reset: got v %b flags %b tag %0d", ifr.rsp_valid, ifr.flags_q, ifr.rsp_tag);
      else passed++;
      @(negedge clk); rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         checks++; if (ifr.rsp_valid !== 1'b0) $display("FAIL mid_after: got %b want 0", ifr.rsp_valid); else passed++;
      end
      ifr.rsp_ready = 1'b1;
   endtask

   task automatic test_random;
      logic        rv [2];
      logic [31:0] ra [2], rb [2];
      logic [4:0]  ru [2];
      logic        rs [2];
      logic [3:0]  rt [2];
      logic        m_valid, m_id;
      logic [31:0] m_res;
      logic [3:0]  m_fl, m_tag, m_flags;
      logic [35:0] e;
      int          m_ptr, g;
      m_valid = 1'b0; m_id = 1'b0; m_res = 32'd0; m_fl = 4'd0; m_tag = 4'd0;
      m_flags = 4'b0000; m_ptr = 0;
      for (int n = 0; n < 2; n++) rv[n] = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int n = 0; n < 2; n++) begin
            if (!rv[n] && $urandom_range(0, 1) == 1) begin
               rv[n] = 1'b1; ra[n] = $urandom(); rb[n] = $urandom();
               ru[n] = 5'($urandom_range(0, 15)); rs[n] = 1'($urandom_range(0, 1));
               rt[n] = 4'($urandom_range(0, 15));
            end
            if (rv[n]) drv_r(n, 1'b1, ra[n], rb[n], ru[n], rs[n], rt[n]);
            else       drv_r(n, 1'b0, 32'd0, 32'd0, OP_NOP, 1'b0, 4'd0);
         end
         ifr.rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         g = -1;
         if (!m_valid || ifr.rsp_ready) begin
            if (rv[0] && rv[1]) g = m_ptr;
            else if (rv[0])     g = 0;
            else if (rv[1])     g = 1;
         end
         checks++;
         if (ifr.req0_ready !== (g == 0) || ifr.req1_ready !== (g == 1))
            $display("FAIL rnd_grant[%0d]: got %b%b want grant %0d", cyc, ifr.req0_ready, ifr.req1_ready, g);
         else passed++;
         checks++;
         if (g >= 0 ? (ifr.alu_uop !== ru[g] || ifr.alu_lhs !== ra[g])
                    : (ifr.alu_uop !== OP_NOP || ifr.alu_lhs !== 32'd0))
            $display("FAIL rnd_alu_drive[%0d]: got uop %0d lhs %h", cyc, ifr.alu_uop, ifr.alu_lhs);
         else passed++;
         if (g >= 0) begin
            e = alu_ref(ra[g], rb[g], ru[g]);
            m_valid = 1'b1; m_id = (g == 1); m_res = e[31:0]; m_fl = e[35:32]; m_tag = rt[g];
            if (rs[g] && sets_flags(ru[g])) m_flags = e[35:32];
            m_ptr = 1 - g;
            rv[g] = 1'b0;
         end else if (ifr.rsp_ready) begin
            m_valid = 1'b0;
         end
         @(posedge clk); #1;
         checks++; if (ifr.rsp_valid !== m_valid) $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", cyc, ifr.rsp_valid, m_valid); else passed++;
         if (m_valid) begin
            checks++;
            if (ifr.rsp_id !== m_id || ifr.rsp_result !== m_res || ifr.rsp_flags !== m_fl || ifr.rsp_tag !== m_tag)
               $display("FAIL rnd_rsp[%0d]: got %b %h %b %h want %b %h %b %h", cyc, ifr.rsp_id, ifr.rsp_result,
                        ifr.rsp_flags, ifr.rsp_tag, m_id, m_res, m_fl, m_tag);
            else passed++;
         end
         checks++; if (ifr.flags_q !== m_flags) $display("FAIL rnd_flags_q[%0d]: got %b want %b", cyc, ifr.flags_q, m_flags); else passed++;
      end
      idle_all();
   endtask

   initial begin
      test_reset();
      test_rr_alternation();
      test_add_flags();
      test_ldr_no_flags();
      test_stall();
      test_fixed_priority();
      test_reset_mid_op();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
